// File: rtl/mips_dbg_pkg.sv
// Shared debug/clock-control definitions for the MIPS core slice.
// Holds the CPU clock controller state encoding, the default clock
// divider and debounce length (reused by the core top and the bench),
// and a small helper that sizes counters.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP_HI,
        STEP_LO
    } clk_ctrl_state_t;

    localparam int unsigned DEF_DIV             = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

    // Bits needed for a counter that runs 0..n-1 (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mips_clk_ctrl_if.sv
// Board-control / CPU-clock bundle of the clock controller.
//   run, step    : raw run switch and step button (towards the controller)
//   CPUCLK       : gated CPU clock
//   cpu_tick     : one-clk pulse while CPUCLK first reads 1
//   cycle_count  : CPUCLK rising edges since reset (CNT_W bits)
//   busy         : CPUCLK is toggling
// master = board/bench side, slave = controller side.
interface mips_clk_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run;
    logic             step;
    logic             CPUCLK;
    logic             cpu_tick;
    logic [CNT_W-1:0] cycle_count;
    logic             busy;

    modport master (
        output run, step,
        input  CPUCLK, cpu_tick, cycle_count, busy
    );

    modport slave (
        input  run, step,
        output CPUCLK, cpu_tick, cycle_count, busy
    );
endinterface

// File: rtl/mips_debounce.sv
// Input conditioner for a raw board signal: 2-FF synchronizer followed
// by a debouncer. dout flips only after the synchronized sample has
// differed from it for CYCLES consecutive clk cycles.
//   clk   : system clock
//   reset : asynchronous, active-high
//   din   : raw asynchronous input
//   dout  : synchronized, debounced level
module mips_debounce
    import mips_dbg_pkg::*;
#(
    parameter int unsigned CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int unsigned   CW   = cnt_width(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            dout       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (sync_2 == dout) begin
                stable_cnt <= '0;
            end else if (stable_cnt == LAST) begin
                // CYCLES-th consecutive differing sample: accept it.
                dout       <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mips_clk_ctrl.sv
// CPU clock and step controller for the pipelined MIPS core.
// Turns the run switch and step button into a registered, gated CPUCLK
// (period 2*DIV clk cycles, 50% duty), a one-clk tick aligned with the
// first high cycle of CPUCLK, and a wrapping CPUCLK rise counter.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : run/step in; CPUCLK, cpu_tick, cycle_count, busy out
module mips_clk_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int unsigned DIV             = DEF_DIV,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    mips_clk_ctrl_if.slave   bus
);

    localparam int unsigned   PW      = cnt_width(DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

    clk_ctrl_state_t  state, state_n;
    logic [PW-1:0]    phase, phase_n;
    logic             clk_q, clk_n;
    logic             tick_q;
    logic             busy_q;
    logic [CNT_W-1:0] count_q;
    logic             run_db, step_db, step_db_q;
    logic             step_req;
    logic             phase_end;
    logic             rise;

    mips_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk   (clk),
        .reset (reset),
        .din   (bus.run),
        .dout  (run_db)
    );

    mips_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk   (clk),
        .reset (reset),
        .din   (bus.step),
        .dout  (step_db)
    );

    assign step_req  = step_db & ~step_db_q;
    assign phase_end = (phase == PH_LAST);
    assign rise      = clk_n & ~clk_q;

    always_comb begin
        state_n = state;
        phase_n = phase + PW'(1);
        clk_n   = clk_q;
        case (state)
            IDLE: begin
                phase_n = '0;
                if (run_db) begin
                    state_n = RUN;
                    clk_n   = 1'b1;
                end else if (step_req) begin
                    state_n = STEP_HI;
                    clk_n   = 1'b1;
                end
            end
            RUN: begin
                // run is only sampled at the end of a low phase, so a
                // stop always finishes the current period.
                if (phase_end) begin
                    phase_n = '0;
                    if (clk_q)       clk_n   = 1'b0;
                    else if (run_db) clk_n   = 1'b1;
                    else             state_n = IDLE;
                end
            end
            STEP_HI: begin
                if (phase_end) begin
                    phase_n = '0;
                    clk_n   = 1'b0;
                    state_n = STEP_LO;
                end
            end
            STEP_LO: begin
                if (phase_end) begin
                    phase_n = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
                clk_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            step_db_q <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            clk_q     <= clk_n;
            tick_q    <= rise;
            busy_q    <= (state_n != IDLE);
            step_db_q <= step_db;
            if (rise) count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.CPUCLK      = clk_q;
    assign bus.cpu_tick    = tick_q;
    assign bus.busy        = busy_q;
    assign bus.cycle_count = count_q;

endmodule
